// File: rtl/mandelbrot_core_if.sv
// mandelbrot_core_if: job request and result handshake bundle for mandelbrot_core.
// Latency: none, wires only.
// Backpressure: valid/ready on both the job side and the result side.
interface mandelbrot_core_if #(
  parameter int FP_BITS = 32,
  parameter int ITER_W  = 16,
  parameter int PIX_W   = 12
);
  logic                      in_valid;
  logic                      in_ready;
  logic signed [FP_BITS-1:0] in_cx;
  logic signed [FP_BITS-1:0] in_cy;
  logic [PIX_W-1:0]          in_xpix;
  logic [PIX_W-1:0]          in_ypix;
  logic [ITER_W-1:0]         iter_max;
  logic                      out_valid;
  logic                      out_ready;
  logic [ITER_W-1:0]         out_iter;
  logic                      out_escaped;
  logic                      out_periodic;
  logic [PIX_W-1:0]          out_xpix;
  logic [PIX_W-1:0]          out_ypix;

  // Producer/consumer side: offers jobs, takes results
  modport master (
    output in_valid, in_cx, in_cy, in_xpix, in_ypix, iter_max, out_ready,
    input  in_ready, out_valid, out_iter, out_escaped, out_periodic, out_xpix, out_ypix
  );

  // Core side
  modport slave (
    input  in_valid, in_cx, in_cy, in_xpix, in_ypix, iter_max, out_ready,
    output in_ready, out_valid, out_iter, out_escaped, out_periodic, out_xpix, out_ypix
  );
endinterface

// File: rtl/mandelbrot_core.sv
// mandelbrot_core: escape-time iterator z <= z^2 + c for one pixel job at a time.
// Latency: one z update per cycle; DONE after out_iter+1 ITER cycles (sooner on a periodicity exit).
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_ready.
// Optional periodicity exit: define MANDEL_PERIOD_CHECK_EN.
module mandelbrot_core #(
  parameter int FP_BITS     = 32,
  parameter int FP_FRAC     = 24,
  parameter int ITER_W      = 16,
  parameter int PIX_W       = 12,
  parameter int PERIOD_LOG2 = 4
) (
  input logic              clk,
  input logic              reset,
  mandelbrot_core_if.slave bus
);
  localparam int W2 = 2 * FP_BITS;
  localparam int W3 = W2 + 1;
  // |z|^2 threshold of 4.0 in the squared (2*FP_FRAC) fixed-point scale
  localparam logic signed [W3-1:0] ESC_LIM = W3'(4) <<< (2 * FP_FRAC);

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t                    state    = IDLE;
  logic signed [FP_BITS-1:0] cx       = '0;
  logic signed [FP_BITS-1:0] cy       = '0;
  logic signed [FP_BITS-1:0] zx       = '0;
  logic signed [FP_BITS-1:0] zy       = '0;
  logic [PIX_W-1:0]          xpix     = '0;
  logic [PIX_W-1:0]          ypix     = '0;
  logic [ITER_W-1:0]         lim      = '0;
  logic [ITER_W-1:0]         n        = '0;
  logic [ITER_W-1:0]         res_iter = '0;
  logic                      res_esc  = 1'b0;

  // Full-precision products and the untruncated magnitude sum
  logic signed [W2-1:0]      xx, yy, xy;
  logic signed [W3-1:0]      mag, diff, xy2;
  logic signed [FP_BITS-1:0] zx_next, zy_next;
  logic                      escape;
  logic                      periodic;
  logic                      accept;

  assign xx      = W2'(zx) * W2'(zx);
  assign yy      = W2'(zy) * W2'(zy);
  assign xy      = W2'(zx) * W2'(zy);
  assign mag     = W3'(xx) + W3'(yy);
  assign diff    = W3'(xx) - W3'(yy);
  assign xy2     = W3'(xy) <<< 1;
  assign escape  = (mag >= ESC_LIM);
  // Rescale back to FP_FRAC fractional bits; overflow wraps silently
  assign zx_next = FP_BITS'(diff >>> FP_FRAC) + cx;
  assign zy_next = FP_BITS'(xy2 >>> FP_FRAC) + cy;
  assign accept  = (state == IDLE) && bus.in_valid;

`ifdef MANDEL_PERIOD_CHECK_EN
  logic signed [FP_BITS-1:0] snap_x  = '0;
  logic signed [FP_BITS-1:0] snap_y  = '0;
  logic                      res_per = 1'b0;
  logic                      snap_now;

  // A cycle that refreshes the snapshot never compares against it
  assign snap_now = (n[PERIOD_LOG2-1:0] == '0);
  assign periodic = !snap_now && (zx == snap_x) && (zy == snap_y);

  // Snapshot z every 2^PERIOD_LOG2 iterations and flag periodicity exits
  always_ff @(posedge clk) begin
    if (reset) begin
      snap_x  <= '0;
      snap_y  <= '0;
      res_per <= 1'b0;
    end else if (accept) begin
      res_per <= 1'b0;
    end else if (state == ITER) begin
      if (snap_now) begin
        snap_x <= zx;
        snap_y <= zy;
      end
      if (!escape && periodic) res_per <= 1'b1;
    end
  end

  assign bus.out_periodic = res_per && !reset;
`else
  assign periodic         = 1'b0;
  assign bus.out_periodic = 1'b0;
`endif

  // Job sequencing: accept, iterate until an exit condition, hold the result
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cx       <= '0;
      cy       <= '0;
      zx       <= '0;
      zy       <= '0;
      xpix     <= '0;
      ypix     <= '0;
      lim      <= '0;
      n        <= '0;
      res_iter <= '0;
      res_esc  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cx      <= bus.in_cx;
            cy      <= bus.in_cy;
            xpix    <= bus.in_xpix;
            ypix    <= bus.in_ypix;
            lim     <= bus.iter_max;
            zx      <= '0;
            zy      <= '0;
            n       <= '0;
            res_esc <= 1'b0;
            state   <= ITER;
          end
        end
        ITER: begin
          if (escape) begin
            res_iter <= n;
            res_esc  <= 1'b1;
            state    <= DONE;
          end else if (periodic) begin
            res_iter <= lim;
            res_esc  <= 1'b0;
            state    <= DONE;
          end else if (n == lim) begin
            res_iter <= n;
            res_esc  <= 1'b0;
            state    <= DONE;
          end else begin
            zx <= zx_next;
            zy <= zy_next;
            n  <= n + ITER_W'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are forced quiet while reset is held
  assign bus.in_ready    = (state == IDLE) && !reset;
  assign bus.out_valid   = (state == DONE) && !reset;
  assign bus.out_iter    = reset ? '0 : res_iter;
  assign bus.out_escaped = res_esc && !reset;
  assign bus.out_xpix    = reset ? '0 : xpix;
  assign bus.out_ypix    = reset ? '0 : ypix;
endmodule

// File: tb/tb_mandelbrot_core.sv
// tb_mandelbrot_core: directed and randomized pixel jobs checked against a wide-integer model.
// Latency is counted in rising edges, the accepting edge being edge 1.
// Backpressure is exercised by withholding out_ready for a number of cycles.
module tb_mandelbrot_core;
  localparam int PERIOD = 16;
  localparam logic signed [31:0] ONE  = 32'sh0100_0000;
  localparam logic signed [31:0] TWO  = 32'sh0200_0000;
  localparam logic signed [31:0] THREE = 32'sh0300_0000;

  logic clk;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  mandelbrot_core_if #(.FP_BITS(32), .ITER_W(16), .PIX_W(12)) bus ();

  mandelbrot_core dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: iterate the escape-time recurrence with 128-bit integers
  task automatic model(input logic signed [31:0] cx, input logic signed [31:0] cy,
                       input logic [15:0] im, output logic [15:0] it,
                       output logic esc, output logic per, output int lat);
    logic signed [31:0]  x, y, sx, sy;
    logic signed [127:0] bx, by, xx, yy, xy;
    x = 0; y = 0; sx = 0; sy = 0;
    esc = 1'b0; per = 1'b0; it = 16'd0; lat = 0;
    for (int k = 0; k <= int'(im); k++) begin
      bx = x; by = y;
      xx = bx * bx; yy = by * by; xy = bx * by;
      if (xx + yy >= (128'sd4 <<< 48)) begin
        esc = 1'b1; it = 16'(k); lat = k + 2; return;
      end
`ifdef MANDEL_PERIOD_CHECK_EN
      if (k % PERIOD == 0) begin
        sx = x; sy = y;
      end else if (x == sx && y == sy) begin
        per = 1'b1; it = im; lat = k + 2; return;
      end
`endif
      if (k == int'(im)) begin
        it = im; lat = k + 2; return;
      end
      x = 32'((xx - yy) >>> 24) + cx;
      y = 32'((2 * xy) >>> 24) + cy;
    end
  endtask

  task automatic run_job(input string tag, input logic signed [31:0] cx, input logic signed [31:0] cy,
                         input logic [11:0] xp, input logic [11:0] yp, input logic [15:0] im,
                         input int stall, input logic [15:0] e_it, input logic e_esc,
                         input logic e_per, input int e_lat);
    int guard;
    int edges;
    @(negedge clk);
    bus.in_cx     = cx;
    bus.in_cy     = cy;
    bus.in_xpix   = xp;
    bus.in_ypix   = yp;
    bus.iter_max  = im;
    bus.in_valid  = 1'b1;
    bus.out_ready = (stall == 0);
    guard = 0;
    while (bus.in_ready !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk({tag, "_in_ready"}, bus.in_ready, 1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    edges = 1;
    guard = 0;
    @(negedge clk);
    while (bus.out_valid !== 1'b1 && guard < e_lat + 20) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      guard++;
    end
    chk({tag, "_out_valid"}, bus.out_valid, 1);
    chk({tag, "_latency"}, edges, e_lat);
    chk({tag, "_iter"}, bus.out_iter, e_it);
    chk({tag, "_escaped"}, bus.out_escaped, e_esc);
    chk({tag, "_periodic"}, bus.out_periodic, e_per);
    chk({tag, "_xpix"}, bus.out_xpix, xp);
    chk({tag, "_ypix"}, bus.out_ypix, yp);
    for (int s = 0; s < stall; s++) begin
      @(posedge clk);
      @(negedge clk);
      chk({tag, "_hold_valid"}, bus.out_valid, 1);
      chk({tag, "_hold_iter"}, bus.out_iter, e_it);
      chk({tag, "_hold_escaped"}, bus.out_escaped, e_esc);
      chk({tag, "_hold_xpix"}, bus.out_xpix, xp);
      chk({tag, "_hold_ypix"}, bus.out_ypix, yp);
      chk({tag, "_hold_in_ready"}, bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_after_in_ready"}, bus.in_ready, 1);
    chk({tag, "_after_out_valid"}, bus.out_valid, 0);
  endtask

  logic signed [31:0] rcx, rcy;
  logic [15:0]        rim, e_it;
  logic [11:0]        rxp, ryp;
  logic               e_esc, e_per, saw;
  int                 e_lat;

  initial begin
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_cx     = '0;
    bus.in_cy     = '0;
    bus.in_xpix   = '0;
    bus.in_ypix   = '0;
    bus.iter_max  = '0;
    bus.out_ready = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_iter", bus.out_iter, 0);
    chk("rst_out_escaped", bus.out_escaped, 0);
    chk("rst_out_periodic", bus.out_periodic, 0);
    chk("rst_out_xpix", bus.out_xpix, 0);
    chk("rst_out_ypix", bus.out_ypix, 0);
    reset = 1'b0;
    #1 chk("rel_in_ready", bus.in_ready, 1);

    run_job("c3",   THREE, 0, 12'd1, 12'd2, 16'd100, 0, 16'd1, 1'b1, 1'b0, 3);
    run_job("cm2",  -TWO,  0, 12'd3, 12'd4, 16'd100, 0, 16'd1, 1'b1, 1'b0, 3);
    run_job("c1",   ONE,   0, 12'd5, 12'd6, 16'd100, 0, 16'd2, 1'b1, 1'b0, 4);
`ifdef MANDEL_PERIOD_CHECK_EN
    run_job("c0",   0,     0, 12'd7, 12'd8, 16'd100, 0, 16'd100, 1'b0, 1'b1, 3);
`else
    run_job("c0",   0,     0, 12'd7, 12'd8, 16'd100, 0, 16'd100, 1'b0, 1'b0, 102);
`endif
    run_job("im0",  THREE, 0, 12'd9, 12'd10, 16'd0, 0, 16'd0, 1'b0, 1'b0, 2);
    run_job("im0b", 32'sh0080_0000, 32'sh0040_0000, 12'd11, 12'd12, 16'd0, 0,
            16'd0, 1'b0, 1'b0, 2);
    run_job("bp",   ONE,   0, 12'd37, 12'd519, 16'd100, 10, 16'd2, 1'b1, 1'b0, 4);

    // Reset in the middle of a long job: the job must vanish without a result
    @(negedge clk);
    bus.in_cx    = 0;
    bus.in_cy    = 0;
    bus.in_xpix  = 12'd77;
    bus.in_ypix  = 12'd88;
    bus.iter_max = 16'd100;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_in_ready", bus.in_ready, 0);
    chk("midrst_out_iter", bus.out_iter, 0);
    chk("midrst_out_xpix", bus.out_xpix, 0);
    @(negedge clk);
    reset = 1'b0;
    #1 chk("midrst_rel_in_ready", bus.in_ready, 1);
    saw = 1'b0;
    repeat (120) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) saw = 1'b1;
    end
    chk("midrst_no_output", saw, 0);
    run_job("post_rst", THREE, 0, 12'd13, 12'd14, 16'd100, 0, 16'd1, 1'b1, 1'b0, 3);

    for (int i = 0; i < 12; i++) begin
      rcx = 32'($urandom_range(0, 32'h0400_0000));
      rcx = rcx - 32'sh0280_0000;
      rcy = 32'($urandom_range(0, 32'h0300_0000));
      rcy = rcy - 32'sh0180_0000;
      rim = 16'($urandom_range(0, 60));
      rxp = 12'($urandom_range(0, 4095));
      ryp = 12'($urandom_range(0, 4095));
      model(rcx, rcy, rim, e_it, e_esc, e_per, e_lat);
      run_job($sformatf("rnd%0d", i), rcx, rcy, rxp, ryp, rim, int'($urandom_range(0, 2)),
              e_it, e_esc, e_per, e_lat);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
